// File: rtl/corr_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : corr_engine_if
//  Purpose  : Bundles the correlation engine's handshake and memory-read
//             signals.
//             - slave  modport: engine side (corr_engine)
//             - master modport: controller / memory side
//  Signals  : iFrameDone, iX, iY        controller -> engine
//             oFbRd, oFbAddr, oTplAddr   engine -> frame buffer / template
//             iFbData, iTplData          memories -> engine
//             oCurrentCorr, oCorrFinished, oBusy  engine -> controller
//  Revision : 1.0 - initial release
// ============================================================================
interface corr_engine_if #(
   parameter int PIX_W  = 8,
   parameter int ADDR_W = 19,
   parameter int CORR_W = 24,
   parameter int TPL_W  = 6
);
   logic              iFrameDone;
   logic [12:0]       iX;
   logic [12:0]       iY;
   logic              oFbRd;
   logic [ADDR_W-1:0] oFbAddr;
   logic [PIX_W-1:0]  iFbData;
   logic [TPL_W-1:0]  oTplAddr;
   logic [PIX_W-1:0]  iTplData;
   logic [CORR_W-1:0] oCurrentCorr;
   logic              oCorrFinished;
   logic              oBusy;

   modport slave (
      input  iFrameDone, iX, iY, iFbData, iTplData,
      output oFbRd, oFbAddr, oTplAddr, oCurrentCorr, oCorrFinished, oBusy
   );

   modport master (
      output iFrameDone, iX, iY, iFbData, iTplData,
      input  oFbRd, oFbAddr, oTplAddr, oCurrentCorr, oCorrFinished, oBusy
   );
endinterface
`default_nettype wire

// File: rtl/corr_engine.sv
`default_nettype none
// ============================================================================
//  Module   : corr_engine
//  Purpose  : Window correlation responder. Latches a window origin once the
//             frame is complete, reads a WIN x WIN frame window together with
//             the template, accumulates the saturating sum of per-pixel
//             differences and presents it with oCorrFinished held high.
//  Ports    : iCLK  - clock, rising edge
//             iRST  - synchronous active-low reset
//             bus   - corr_engine_if.slave (handshake + memory read ports)
//  Options  : CORR_SQUARED_EN - when defined, each term is the squared
//             difference (SSD); otherwise the absolute difference (SAD).
//  Revision : 1.0 - initial release
// ============================================================================
module corr_engine #(
   parameter int WIN    = 8,
   parameter int PIX_W  = 8,
   parameter int CORR_W = 24,
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480,
   parameter int ADDR_W = 19,
   parameter int RD_LAT = 2
) (
   input wire logic     iCLK,
   input wire logic     iRST,
   corr_engine_if.slave bus
);

   localparam int c_N     = WIN * WIN;
   localparam int c_TPL_W = $clog2(c_N);
   localparam int c_COL_W = $clog2(WIN);
   localparam int c_CNT_W = $clog2(RD_LAT + 2);
`ifdef CORR_SQUARED_EN
   localparam int c_TERM_W = 2 * PIX_W;
`else
   localparam int c_TERM_W = PIX_W;
`endif
   localparam logic [c_TPL_W-1:0] c_IDX_LAST  = c_TPL_W'(c_N - 1);
   localparam logic [c_COL_W-1:0] c_COL_LAST  = c_COL_W'(WIN - 1);
   localparam logic [c_CNT_W-1:0] c_DRAIN_END = c_CNT_W'(RD_LAT + 1);
   localparam logic [ADDR_W-1:0]  c_STRIDE    = ADDR_W'(IMG_W);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              r_state;
   logic                r_first;
   logic [12:0]         r_x0;
   logic [12:0]         r_y0;
   logic                r_rd;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W-1:0]   r_rowbase;
   logic [c_TPL_W-1:0]  r_idx;
   logic [c_COL_W-1:0]  r_col;
   logic [c_CNT_W-1:0]  r_cnt;
   logic [RD_LAT:1]     r_vld;
   logic [CORR_W-1:0]   r_acc;
   logic [CORR_W-1:0]   r_corr;
   logic                r_fin;
   logic                r_busy;

   logic                w_changed;
   logic                w_start;
   logic                w_oob;
   logic [ADDR_W-1:0]   w_base;
   logic [PIX_W-1:0]    w_diff;
   logic [c_TERM_W-1:0] w_term;
   logic [CORR_W:0]     w_sum;
   logic [CORR_W-1:0]   w_acc_next;

   assign bus.oFbRd         = r_rd;
   assign bus.oFbAddr       = r_addr;
   assign bus.oTplAddr      = r_idx;
   assign bus.oCurrentCorr  = r_corr;
   assign bus.oCorrFinished = r_fin;
   assign bus.oBusy         = r_busy;

   // A job starts from IDLE on the first frame after reset or on a new origin;
   // from DONE only a new origin restarts (a low iFrameDone goes to IDLE).
   assign w_changed = (bus.iX != r_x0) || (bus.iY != r_y0);
   assign w_start   = bus.iFrameDone &&
                      (((r_state == S_IDLE) && (r_first || w_changed)) ||
                       ((r_state == S_DONE) && w_changed));
   assign w_oob     = (({19'd0, bus.iX} + 32'(WIN)) > 32'(IMG_W)) ||
                      (({19'd0, bus.iY} + 32'(WIN)) > 32'(IMG_H));
   // Address arithmetic wraps modulo 2^ADDR_W.
   assign w_base    = ADDR_W'(({19'd0, bus.iY} * 32'(IMG_W)) + {19'd0, bus.iX});

   always_comb begin
      w_diff = (bus.iFbData >= bus.iTplData) ? (bus.iFbData - bus.iTplData)
                                             : (bus.iTplData - bus.iFbData);
`ifdef CORR_SQUARED_EN
      w_term = c_TERM_W'(w_diff) * c_TERM_W'(w_diff);
`else
      w_term = w_diff;
`endif
      w_sum      = {1'b0, r_acc} + (CORR_W+1)'(w_term);
      // Carry out means overflow: pin at all-ones; all-ones plus any term
      // either stays all-ones or carries again, so saturation is sticky.
      w_acc_next = w_sum[CORR_W] ? '1 : w_sum[CORR_W-1:0];
   end

   always_ff @(posedge iCLK) begin
      if (!iRST) begin
         r_state   <= S_IDLE;
         r_first   <= 1'b1;
         r_x0      <= '0;
         r_y0      <= '0;
         r_rd      <= 1'b0;
         r_addr    <= '0;
         r_rowbase <= '0;
         r_idx     <= '0;
         r_col     <= '0;
         r_cnt     <= '0;
         r_vld     <= '0;
         r_acc     <= '0;
         r_corr    <= '0;
         r_fin     <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         // Read-valid pipeline mirrors the memory latency.
         r_vld[1] <= r_rd;
         for (int i = 2; i <= RD_LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
         end
         if (r_vld[RD_LAT]) begin
            r_acc <= w_acc_next;
         end

         if (w_start) begin
            r_first   <= 1'b0;
            r_x0      <= bus.iX;
            r_y0      <= bus.iY;
            r_busy    <= 1'b1;
            r_fin     <= 1'b0;
            r_idx     <= '0;
            r_col     <= '0;
            r_rowbase <= w_base;
            r_addr    <= w_base;
            if (w_oob) begin
               // No reads: preload the saturated score and let DRAIN time
               // out after one cycle so the result appears two edges later.
               r_acc   <= '1;
               r_rd    <= 1'b0;
               r_cnt   <= c_CNT_W'(RD_LAT);
               r_state <= S_DRAIN;
            end else begin
               r_acc   <= '0;
               r_rd    <= 1'b1;
               r_state <= S_ISSUE;
            end
         end else begin
            case (r_state)
               S_ISSUE, S_DRAIN: begin
                  if (!bus.iFrameDone) begin
                     r_rd    <= 1'b0;
                     r_busy  <= 1'b0;
                     r_vld   <= '0;
                     r_state <= S_IDLE;
                  end else if (r_state == S_ISSUE) begin
                     if (r_idx == c_IDX_LAST) begin
                        r_rd    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_DRAIN;
                     end else begin
                        r_idx <= r_idx + 1'b1;
                        if (r_col == c_COL_LAST) begin
                           r_col     <= '0;
                           r_rowbase <= r_rowbase + c_STRIDE;
                           r_addr    <= r_rowbase + c_STRIDE;
                        end else begin
                           r_col  <= r_col + 1'b1;
                           r_addr <= r_addr + 1'b1;
                        end
                     end
                  end else if (r_cnt == c_DRAIN_END) begin
                     r_corr  <= r_acc;
                     r_fin   <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= S_DONE;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               S_DONE: begin
                  if (!bus.iFrameDone) begin
                     r_fin   <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_corr_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_corr_engine
//  Purpose  : Self-checking bench for corr_engine. Models both read memories
//             with RD_LAT latency, checks every issued read address against a
//             queue, and compares each score against an independent model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_corr_engine;
   localparam int WIN    = 8;
   localparam int PIX_W  = 8;
   localparam int CORR_W = 24;
   localparam int IMG_W  = 640;
   localparam int IMG_H  = 480;
   localparam int ADDR_W = 19;
   localparam int RD_LAT = 2;
   localparam int TPL_W  = 6;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   corr_engine_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W), .CORR_W(CORR_W), .TPL_W(TPL_W)) bus ();

   corr_engine #(
      .WIN(WIN), .PIX_W(PIX_W), .CORR_W(CORR_W), .IMG_W(IMG_W),
      .IMG_H(IMG_H), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)
   ) dut (
      .iCLK (clk),
      .iRST (rst_n),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   int rd_count = 0;
   int fb_mode, fb_val, tpl_mode, tpl_val;
   logic [23:0] last_corr;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [TPL_W-1:0]  tpl;
   } rd_t;
   rd_t         addr_q[$];
   logic [23:0] exp_q[$];

   typedef struct {
      int          x, y, fbm, fbv, tplm, tplv, lat, reads;
      bit          use_const;
      logic [23:0] corr;
   } vec_t;

   function automatic logic [7:0] fb_pix(input logic [ADDR_W-1:0] a);
      logic [31:0] v;
      v = 32'(a);
      if (fb_mode == 0) return 8'(fb_val);
      return 8'((v * 7) ^ (v >> 3));
   endfunction

   function automatic logic [7:0] tpl_pix(input int idx);
      if (tpl_mode == 0) return 8'(tpl_val);
      return 8'(idx * 29 + 3);
   endfunction

   function automatic bit oob(input int x, input int y);
      return (x + WIN > IMG_W) || (y + WIN > IMG_H);
   endfunction

   function automatic logic [23:0] model_corr(input int x, input int y);
      longint acc = 0;
      if (oob(x, y)) return 24'hFFFFFF;
      for (int r = 0; r < WIN; r++) begin
         for (int c = 0; c < WIN; c++) begin
            int a, f, t, d;
            a = ((y + r) * IMG_W + x + c) % (1 << ADDR_W);
            f = int'(fb_pix(ADDR_W'(a)));
            t = int'(tpl_pix(r * WIN + c));
            d = (f > t) ? f - t : t - f;
`ifdef CORR_SQUARED_EN
            acc += d * d;
`else
            acc += d;
`endif
            if (acc > 64'hFFFFFF) acc = 64'hFFFFFF;
         end
      end
      return 24'(acc);
   endfunction

   function automatic void push_reads(input int x, input int y);
      rd_t e;
      if (oob(x, y)) return;
      for (int r = 0; r < WIN; r++) begin
         for (int c = 0; c < WIN; c++) begin
            e.addr = ADDR_W'(((y + r) * IMG_W + x + c) % (1 << ADDR_W));
            e.tpl  = TPL_W'(r * WIN + c);
            addr_q.push_back(e);
         end
      end
   endfunction

   function automatic void push_job(input int x, input int y, input bit use_const,
                                    input logic [23:0] cval);
      push_reads(x, y);
      exp_q.push_back(use_const ? cval : model_corr(x, y));
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Memories: RD_LAT register stages from strobe to data.
   logic [7:0] fb_s  [1:RD_LAT];
   logic [7:0] tpl_s [1:RD_LAT];
   always @(posedge clk) begin
      fb_s[1]  <= bus.oFbRd ? fb_pix(bus.oFbAddr) : 8'h00;
      tpl_s[1] <= bus.oFbRd ? tpl_pix(int'(bus.oTplAddr)) : 8'h00;
      for (int i = 2; i <= RD_LAT; i++) begin
         fb_s[i]  <= fb_s[i-1];
         tpl_s[i] <= tpl_s[i-1];
      end
   end
   assign bus.iFbData  = fb_s[RD_LAT];
   assign bus.iTplData = tpl_s[RD_LAT];

   // Read-address scoreboard.
   always @(negedge clk) begin : mon
      rd_t e;
      if (bus.oFbRd) begin
         rd_count++;
         n_checks++;
         if (addr_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_read: got addr %0d expected no read", bus.oFbAddr);
         end else begin
            e = addr_q.pop_front();
            if (bus.oFbAddr !== e.addr || bus.oTplAddr !== e.tpl) begin
               n_errors++;
               $display("FAIL read_addr: got fb %0d tpl %0d expected fb %0d tpl %0d",
                        bus.oFbAddr, bus.oTplAddr, e.addr, e.tpl);
            end
         end
      end
   end

   // Start is sampled at the next rising edge; returns at the negedge after
   // oCorrFinished is first seen high.
   task automatic wait_done(input string name, input int exp_lat, input int exp_reads);
      int cyc;
      logic [23:0] e;
      rd_count = 0;
      @(posedge clk);
      @(negedge clk);
      check({name, "_fin_low"}, 32'(bus.oCorrFinished), 0);
      check({name, "_busy"}, 32'(bus.oBusy), 1);
      cyc = 0;
      while (!bus.oCorrFinished && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      check({name, "_latency"}, cyc, exp_lat);
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s_corr: got %0d expected a queued result", name, bus.oCurrentCorr);
      end else begin
         e = exp_q.pop_front();
         check({name, "_corr"}, 32'(bus.oCurrentCorr), 32'(e));
         last_corr = e;
      end
      check({name, "_reads"}, rd_count, exp_reads);
      check({name, "_addr_left"}, addr_q.size(), 0);
      check({name, "_busy_done"}, 32'(bus.oBusy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   vec_t vecs [7];

   initial begin
      int n;
      vecs[0] = '{x:0,   y:0,   fbm:0, fbv:16,  tplm:0, tplv:16,  lat:68, reads:64, use_const:1, corr:24'd0};
`ifdef CORR_SQUARED_EN
      vecs[1] = '{x:1,   y:0,   fbm:0, fbv:255, tplm:0, tplv:0,   lat:68, reads:64, use_const:1, corr:24'd4161600};
`else
      vecs[1] = '{x:1,   y:0,   fbm:0, fbv:255, tplm:0, tplv:0,   lat:68, reads:64, use_const:1, corr:24'd16320};
`endif
      vecs[2] = '{x:636, y:0,   fbm:0, fbv:0,   tplm:0, tplv:0,   lat:2,  reads:0,  use_const:1, corr:24'hFFFFFF};
      vecs[3] = '{x:0,   y:472, fbm:1, fbv:0,   tplm:1, tplv:0,   lat:68, reads:64, use_const:0, corr:24'd0};
      vecs[4] = '{x:632, y:0,   fbm:1, fbv:0,   tplm:0, tplv:100, lat:68, reads:64, use_const:0, corr:24'd0};
      vecs[5] = '{x:0,   y:473, fbm:1, fbv:0,   tplm:1, tplv:0,   lat:2,  reads:0,  use_const:1, corr:24'hFFFFFF};
      vecs[6] = '{x:100, y:50,  fbm:1, fbv:0,   tplm:1, tplv:0,   lat:68, reads:64, use_const:0, corr:24'd0};

      fb_mode = 0; fb_val = 0; tpl_mode = 0; tpl_val = 0;
      bus.iFrameDone = 1'b0;
      bus.iX = '0;
      bus.iY = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_rd",   32'(bus.oFbRd), 0);
      check("rst_addr", 32'(bus.oFbAddr), 0);
      check("rst_tpl",  32'(bus.oTplAddr), 0);
      check("rst_corr", 32'(bus.oCurrentCorr), 0);
      check("rst_fin",  32'(bus.oCorrFinished), 0);
      check("rst_busy", 32'(bus.oBusy), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_no_frame_busy", 32'(bus.oBusy), 0);

      // Table-driven jobs; each origin differs from the previous one
      for (int i = 0; i < 7; i++) begin
         fb_mode = vecs[i].fbm;  fb_val = vecs[i].fbv;
         tpl_mode = vecs[i].tplm; tpl_val = vecs[i].tplv;
         push_job(vecs[i].x, vecs[i].y, vecs[i].use_const, vecs[i].corr);
         bus.iX = 13'(vecs[i].x);
         bus.iY = 13'(vecs[i].y);
         bus.iFrameDone = 1'b1;
         wait_done($sformatf("vec%0d", i), vecs[i].lat, vecs[i].reads);
      end

      // Abort: drop iFrameDone after 30 reads
      push_reads(200, 100);
      bus.iX = 13'd200;
      bus.iY = 13'd100;
      rd_count = 0;
      n = 0;
      while (rd_count < 30 && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("abort_reads_before", rd_count, 30);
      bus.iFrameDone = 1'b0;
      @(negedge clk);
      check("abort_rd",   32'(bus.oFbRd), 0);
      check("abort_busy", 32'(bus.oBusy), 0);
      check("abort_fin",  32'(bus.oCorrFinished), 0);
      check("abort_corr", 32'(bus.oCurrentCorr), 32'(last_corr));
      repeat (10) @(negedge clk);
      check("abort_fin_hold",  32'(bus.oCorrFinished), 0);
      check("abort_corr_hold", 32'(bus.oCurrentCorr), 32'(last_corr));
      check("abort_reads_after", rd_count, 30);
      addr_q.delete();

      // iY change during ISSUE: restart right after DONE
      bus.iFrameDone = 1'b1;
      bus.iX = 13'd10;
      bus.iY = 13'd10;
      push_job(10, 10, 1'b0, 24'd0);
      fork
         wait_done("ychg_first", 68, 64);
         begin
            repeat (20) @(negedge clk);
            bus.iY = 13'd11;
         end
      join
      push_job(10, 11, 1'b0, 24'd0);
      wait_done("ychg_second", 68, 64);

      // Reset mid-ISSUE, then restart without an origin change
      bus.iX = 13'd20;
      bus.iY = 13'd20;
      push_job(20, 20, 1'b0, 24'd0);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_rd",   32'(bus.oFbRd), 0);
      check("midrst_addr", 32'(bus.oFbAddr), 0);
      check("midrst_tpl",  32'(bus.oTplAddr), 0);
      check("midrst_corr", 32'(bus.oCurrentCorr), 0);
      check("midrst_fin",  32'(bus.oCorrFinished), 0);
      check("midrst_busy", 32'(bus.oBusy), 0);
      addr_q.delete();
      void'(exp_q.pop_back());
      rst_n = 1'b1;
      push_job(20, 20, 1'b0, 24'd0);
      wait_done("midrst_rerun", 68, 64);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
